// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
//   Shared definitions for the program-counter sequencer.
//   Contents:
//     pc_state_e           - sequencer FSM states (BOOT, RUN, HALT)
//     DEFAULT_RESET_VECTOR - fetch address used after reset unless overridden
//     FETCH_COUNT_WIDTH    - width of the retired-fetch counter
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  // BOOT spends one cycle loading the reset vector, RUN fetches, and HALT
  // parks the PC until resume.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  localparam int FETCH_COUNT_WIDTH = 32;

endpackage : pc_seq_pkg

// File: rtl/pc_incrementer.sv
// ---------------------------------------------------------------------------
// pc_incrementer
//   Produces the sequential successor of a program counter. The addition is
//   unsigned modulo 2^WIDTH, so the all-ones address wraps to zero and no
//   carry is reported.
//   Ports:
//     pc_i        in  WIDTH  current fetch address
//     pc_plus1_o  out WIDTH  pc_i + 1 (combinational)
// ---------------------------------------------------------------------------
module pc_incrementer #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] pc_plus1_o
);

  // The carry out of the top bit is dropped on purpose; this is what gives
  // the silent wrap from the last address back to address zero.
  assign pc_plus1_o = pc_i + WIDTH'(1);

endmodule : pc_incrementer

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer with a three-state control FSM. After reset it
//   spends one BOOT cycle presenting RESET_VECTOR, then fetches in RUN,
//   choosing the next PC with priority halt > stall > jump > branch > pc+1.
//   HALT parks the PC until resume. A 32-bit counter tracks the number of
//   cycles in which a fetch actually advanced.
//   Ports:
//     clk            in   1      rising-edge clock
//     reset          in   1      synchronous active-high reset
//     stall          in   1      hold PC this cycle
//     branch_taken   in   1      redirect to branch_target
//     branch_target  in   WIDTH  branch destination (word address)
//     jump           in   1      redirect to jump_target (beats branch)
//     jump_target    in   WIDTH  jump destination (word address)
//     halt           in   1      request entry to HALT
//     resume         in   1      request exit from HALT
//     pc             out  WIDTH  current fetch address (registered)
//     pc_plus1       out  WIDTH  pc + 1 (combinational from pc)
//     pc_valid       out  1      pc is an instruction to execute (registered)
//     halted         out  1      FSM is in HALT (registered)
//     fetch_count    out  32     count of non-stalled valid cycles (registered)
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [WIDTH-1:0]             branch_target,
  input  logic                         jump,
  input  logic [WIDTH-1:0]             jump_target,
  input  logic                         halt,
  input  logic                         resume,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus1,
  output logic                         pc_valid,
  output logic                         halted,
  output logic [FETCH_COUNT_WIDTH-1:0] fetch_count
);

  pc_state_e                    state_q, state_d;
  logic [WIDTH-1:0]             pc_q, pc_d;
  logic                         pc_valid_q, pc_valid_d;
  logic                         halted_q, halted_d;
  logic [FETCH_COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
  logic                         fetch_advance;

  pc_incrementer #(
    .WIDTH (WIDTH)
  ) u_pc_incrementer (
    .pc_i       (pc_q),
    .pc_plus1_o (pc_plus1)
  );

  // Control FSM next state. BOOT always moves on to RUN regardless of the
  // inputs. In HALT, a simultaneous halt request outweighs resume so the
  // sequencer stays parked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (resume && !halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // The status outputs are registered copies of the upcoming state, so they
  // come straight from flops yet line up with the state they describe.
  always_comb begin
    pc_valid_d = (state_d == RUN);
    halted_d   = (state_d == HALT);
  end

  // Next-PC selection. Only an un-stalled, non-halting RUN cycle advances
  // the PC; a redirect seen during a stall or in HALT is simply dropped
  // and never remembered. jump is checked before branch_taken, so jump wins
  // when both are raised together. Targets are loaded unmodified.
  always_comb begin
    pc_d          = pc_q;
    fetch_advance = 1'b0;
    case (state_q)
      BOOT: pc_d = RESET_VECTOR;
      RUN: begin
        if (!halt && !stall) begin
          fetch_advance = 1'b1;
          if (jump) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_plus1;
          end
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // The fetch counter only moves on cycles where the PC really advanced;
  // it wraps naturally at 2^32.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (fetch_advance) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State and output registers. Reset is synchronous and overrides every
  // other input, so a reset in the middle of RUN or HALT looks exactly like
  // a power-on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer (WIDTH=32, RESET_VECTOR=0x100). Each
//   stimulus step pushes the hand-computed outputs expected during that
//   cycle into a queue; an independent monitor pops and compares on every
//   falling edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pcPlus1;
  logic        pcValid;
  logic        halted;
  logic [31:0] fetchCount;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   stepIdx  = 0;

  pc_sequencer #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .jump          (jump),
    .jump_target   (jumpTarget),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .pc_plus1      (pcPlus1),
    .pc_valid      (pcValid),
    .halted        (halted),
    .fetch_count   (fetchCount)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison; every call counts toward the summary.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL step%0d %s actual=%h required=%h", stepIdx, name,
               actual, required);
    end
  endtask

  // Monitor: on each falling edge, compare the DUT against the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      stepIdx++;
      checkOutput("pc",          pc,                  e.pc);
      checkOutput("pc_plus1",    pcPlus1,             e.pc + 32'd1);
      checkOutput("pc_valid",    {31'd0, pcValid},    {31'd0, e.valid});
      checkOutput("halted",      {31'd0, halted},     {31'd0, e.halted});
      checkOutput("fetch_count", fetchCount,          e.count);
    end
  end

  // One cycle: just after the rising edge, record what the DUT should be
  // showing now, then drive the inputs that the next edge will sample.
  task automatic applyStimulus(
    input logic [31:0] expPc, input logic expValid, input logic expHalted,
    input logic [31:0] expCount,
    input logic rst, input logic stl, input logic hlt, input logic res,
    input logic jmp, input logic [31:0] jt,
    input logic br,  input logic [31:0] bt);
    exp_t e;
    @(posedge clk);
    #1;
    e.pc     = expPc;
    e.valid  = expValid;
    e.halted = expHalted;
    e.count  = expCount;
    expQ.push_back(e);
    reset        = rst;
    stall        = stl;
    halt         = hlt;
    resume       = res;
    jump         = jmp;
    jumpTarget   = jt;
    branchTaken  = br;
    branchTarget = bt;
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    jump = 1'b0; jumpTarget = '0; branchTaken = 1'b0; branchTarget = '0;
    repeat (2) @(posedge clk);

    //            expPc         v  h  cnt    rst stl hlt res jmp jt            br  bt
    // Reset state (BOOT), then idle fetches from the reset vector.
    applyStimulus(32'h100,      0, 0, 0,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    applyStimulus(32'h100,      1, 0, 0,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    applyStimulus(32'h101,      1, 0, 1,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    applyStimulus(32'h102,      1, 0, 2,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    // Jump to 0x10, then jump and branch together: jump wins.
    applyStimulus(32'h103,      1, 0, 3,     0,  0,  0,  0,  1,  32'h10,       0,  32'h0);
    applyStimulus(32'h10,       1, 0, 4,     0,  0,  0,  0,  1,  32'h40,       1,  32'h80);
    // Branch alone to 0x20, then stall two cycles with a branch pending.
    applyStimulus(32'h40,       1, 0, 5,     0,  0,  0,  0,  0,  32'h0,        1,  32'h20);
    applyStimulus(32'h20,       1, 0, 6,     0,  1,  0,  0,  0,  32'h0,        1,  32'h99);
    applyStimulus(32'h20,       1, 0, 6,     0,  1,  0,  0,  0,  32'h0,        1,  32'h99);
    applyStimulus(32'h20,       1, 0, 6,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    // Jump to 0x30, halt (with a jump that must be ignored), sit in HALT.
    applyStimulus(32'h21,       1, 0, 7,     0,  0,  0,  0,  1,  32'h30,       0,  32'h0);
    applyStimulus(32'h30,       1, 0, 8,     0,  0,  1,  0,  1,  32'h77,       0,  32'h0);
    applyStimulus(32'h30,       0, 1, 8,     0,  1,  0,  0,  1,  32'h66,       1,  32'h11);
    applyStimulus(32'h30,       0, 1, 8,     0,  0,  1,  1,  0,  32'h0,        0,  32'h0);
    applyStimulus(32'h30,       0, 1, 8,     0,  0,  0,  1,  0,  32'h0,        0,  32'h0);
    // Back in RUN at the same pc, then sequential advance.
    applyStimulus(32'h30,       1, 0, 8,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    // Jump to the top address and wrap to zero.
    applyStimulus(32'h31,       1, 0, 9,     0,  0,  0,  0,  1,  32'hFFFF_FFFF, 0, 32'h0);
    applyStimulus(32'hFFFF_FFFF,1, 0, 10,    0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    // From 0, jump to 0x55 and halt there.
    applyStimulus(32'h0,        1, 0, 11,    0,  0,  0,  0,  1,  32'h55,       0,  32'h0);
    applyStimulus(32'h55,       1, 0, 12,    0,  0,  1,  0,  0,  32'h0,        0,  32'h0);
    // Reset in HALT with a jump present: reset overrides it.
    applyStimulus(32'h55,       0, 1, 12,    1,  0,  0,  0,  1,  32'h999,      0,  32'h0);
    // BOOT ignores halt and jump.
    applyStimulus(32'h100,      0, 0, 0,     0,  0,  1,  0,  1,  32'h500,      0,  32'h0);
    applyStimulus(32'h100,      1, 0, 0,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    // Reset in RUN with a branch present.
    applyStimulus(32'h101,      1, 0, 1,     1,  0,  0,  0,  0,  32'h0,        1,  32'h222);
    applyStimulus(32'h100,      0, 0, 0,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    applyStimulus(32'h100,      1, 0, 0,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);
    applyStimulus(32'h101,      1, 0, 1,     0,  0,  0,  0,  0,  32'h0,        0,  32'h0);

    // Let the monitor drain the queue, bounded by a few cycles.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc_sequencer
